// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 operate-instruction sequencer.
//   - opcode constants for the legal operate instructions (ADD, AND, NOT)
//   - sequencer FSM state encoding
//   - architectural condition-code reset value
//   - is_operate(): true for an opcode the sequencer executes
package lc3_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;

    localparam logic [2:0] NZP_RST = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic is_operate(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// lc3_regfile: 8 x 16 LC-3 general-purpose register file.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (all registers to 0)
//   we, waddr, wdata    synchronous write port
//   raddr1/rdata1       asynchronous read port 1
//   raddr2/rdata2       asynchronous read port 2
//   dbg_addr/dbg_data   extra asynchronous read port, only with LC3_ALU_SEQ_DBG_EN defined
module lc3_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  raddr1,
    output logic [15:0] rdata1,
    input  logic [2:0]  raddr2,
    output logic [15:0] rdata2
`ifdef LC3_ALU_SEQ_DBG_EN
    ,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
`endif
);

    logic [15:0] regs [8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

`ifdef LC3_ALU_SEQ_DBG_EN
    assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/lc3_alu_seq.sv
// lc3_alu_seq: sequencer for LC-3 operate instructions (ADD, AND, NOT).
// Accepts one instruction over valid/ready, reads operands from the register
// file, drives the external ALU, waits ALU_LAT cycles, writes back and updates NZP.
// Parameter: ALU_LAT (1..8) cycles from operands applied to alu_out/alu_nzp valid.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid, in_instr, in_ready instruction handshake (in_ready = idle)
//   alu_a, alu_b, alu_op        registered ALU operands / opcode
//   alu_out, alu_nzp            ALU result and flags
//   done, err, wb_dr, wb_data   retire pulse and its write-back info
//   nzp                         architectural condition codes
// Macro LC3_ALU_SEQ_DBG_EN adds dbg_addr/dbg_data (combinational register peek).
module lc3_alu_seq
    import lc3_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic [2:0]  alu_nzp,
    output logic        done,
    output logic        err,
    output logic [2:0]  wb_dr,
    output logic [15:0] wb_data,
    output logic [2:0]  nzp
`ifdef LC3_ALU_SEQ_DBG_EN
    ,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  dr_q;

    logic        accept;
    logic        legal;
    logic        last_exec;
    logic [3:0]  op_in;
    logic [15:0] rdata1, rdata2;
    logic [15:0] imm5;
    logic [15:0] b_next;

    assign in_ready  = (state_q == IDLE);
    assign done      = (state_q == WB);
    assign accept    = in_valid && in_ready;
    assign op_in     = in_instr[15:12];
    assign legal     = is_operate(op_in);
    assign last_exec = (state_q == EXEC) && (cnt_q == 4'd1);
    assign imm5      = {{11{in_instr[4]}}, in_instr[4:0]};

    always_comb begin
        b_next = rdata2;
        if (op_in == OP_NOT) begin
            b_next = 16'h0000;
        end else if (in_instr[5]) begin
            b_next = imm5;
        end
    end

`ifdef LC3_ALU_SEQ_DBG_EN
    lc3_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (last_exec),
        .waddr    (dr_q),
        .wdata    (alu_out),
        .raddr1   (in_instr[8:6]),
        .rdata1   (rdata1),
        .raddr2   (in_instr[2:0]),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );
`else
    lc3_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (last_exec),
        .waddr  (dr_q),
        .wdata  (alu_out),
        .raddr1 (in_instr[8:6]),
        .rdata1 (rdata1),
        .raddr2 (in_instr[2:0]),
        .rdata2 (rdata2)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = legal ? EXEC : WB;
                    cnt_d   = CNT_INIT;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd1) begin
                    state_d = WB;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= 16'h0000;
            alu_b   <= 16'h0000;
            alu_op  <= 4'b0000;
            dr_q    <= 3'd0;
            err     <= 1'b0;
            wb_dr   <= 3'd0;
            wb_data <= 16'h0000;
            nzp     <= NZP_RST;
        end else begin
            if (accept) begin
                if (legal) begin
                    alu_a  <= rdata1;
                    alu_b  <= b_next;
                    alu_op <= op_in;
                    dr_q   <= in_instr[11:9];
                end else begin
                    // Illegal opcode leaves the ALU side untouched; retire with error.
                    err     <= 1'b1;
                    wb_dr   <= 3'd0;
                    wb_data <= 16'h0000;
                end
            end
            if (last_exec) begin
                err     <= 1'b0;
                wb_dr   <= dr_q;
                wb_data <= alu_out;
                nzp     <= alu_nzp;
            end
        end
    end

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Bench for lc3_alu_seq: two DUTs, one with a combinational ALU (ALU_LAT=1)
// and one with a single-register ALU (ALU_LAT=2), exercised one after the other.
module tb_lc3_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-driven inputs, indexed by DUT instance.
    logic        rst      [2];
    logic        in_valid [2];
    logic [15:0] in_instr [2];

    // DUT outputs gathered into arrays for indexed access.
    logic        in_ready_v [2];
    logic [15:0] alu_a_v    [2];
    logic [15:0] alu_b_v    [2];
    logic [3:0]  alu_op_v   [2];
    logic        done_v     [2];
    logic        err_v      [2];
    logic [2:0]  wb_dr_v    [2];
    logic [15:0] wb_data_v  [2];
    logic [2:0]  nzp_v      [2];

    logic        r0, r1, d0, d1, e0, e1;
    logic [15:0] a0, a1, b0, b1, wd0, wd1, ao0, ao1;
    logic [3:0]  op0, op1;
    logic [2:0]  dr0, dr1, n0, n1, an0, an1;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        case (op)
            4'b0001: return a + b;
            4'b0101: return a & b;
            4'b1001: return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [2:0] flags_f(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    // ALU models: combinational for instance 0, one register stage for instance 1.
    assign ao0 = alu_f(a0, b0, op0);
    assign an0 = flags_f(ao0);
    always_ff @(posedge clk) begin
        ao1 <= alu_f(a1, b1, op1);
        an1 <= flags_f(alu_f(a1, b1, op1));
    end

    lc3_alu_seq #(.ALU_LAT(1)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_instr(in_instr[0]),
        .in_ready(r0), .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_out(ao0),
        .alu_nzp(an0), .done(d0), .err(e0), .wb_dr(dr0), .wb_data(wd0), .nzp(n0)
    );

    lc3_alu_seq #(.ALU_LAT(2)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_instr(in_instr[1]),
        .in_ready(r1), .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_out(ao1),
        .alu_nzp(an1), .done(d1), .err(e1), .wb_dr(dr1), .wb_data(wd1), .nzp(n1)
    );

    always_comb begin
        in_ready_v[0] = r0;  in_ready_v[1] = r1;
        alu_a_v[0]    = a0;  alu_a_v[1]    = a1;
        alu_b_v[0]    = b0;  alu_b_v[1]    = b1;
        alu_op_v[0]   = op0; alu_op_v[1]   = op1;
        done_v[0]     = d0;  done_v[1]     = d1;
        err_v[0]      = e0;  err_v[1]      = e1;
        wb_dr_v[0]    = dr0; wb_dr_v[1]    = dr1;
        wb_data_v[0]  = wd0; wb_data_v[1]  = wd1;
        nzp_v[0]      = n0;  nzp_v[1]      = n1;
    end

    int errors = 0;
    int checks = 0;
    int cur_k  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (ALU_LAT=%0d): got %h expected %h", name, cur_k + 1, act, exp);
        end
    endtask

    // Architectural reference model: register array, condition codes, last ALU opcode.
    logic [15:0] mregs [8];
    logic [2:0]  mnzp;
    logic [3:0]  mop;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  dr;
        logic [15:0] data;
        logic [2:0]  nzp;
        logic        err;
    } vec_t;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        mnzp = 3'b010;
        mop  = 4'b0000;
    endtask

    task automatic model(input logic [15:0] instr, output vec_t e);
        logic [3:0]  op;
        logic [15:0] a, b, r;
        op = instr[15:12];
        e.instr = instr;
        if (op != 4'b0001 && op != 4'b0101 && op != 4'b1001) begin
            e.err = 1'b1; e.dr = 3'd0; e.data = 16'h0000; e.nzp = mnzp;
        end else begin
            a = mregs[instr[8:6]];
            b = instr[5] ? 16'($signed(instr[4:0])) : mregs[instr[2:0]];
            if (op == 4'b0001)      r = a + b;
            else if (op == 4'b0101) r = a & b;
            else                    r = ~a;
            mregs[instr[11:9]] = r;
            mnzp = (r == 16'h0000) ? 3'b010 : ($signed(r) < 0 ? 3'b100 : 3'b001);
            mop  = op;
            e.err = 1'b0; e.dr = instr[11:9]; e.data = r; e.nzp = mnzp;
        end
    endtask

    task automatic do_reset(input int k);
        in_valid[k] = 1'b0;
        in_instr[k] = 16'h0000;
        rst[k] = 1'b1;
        repeat (2) @(negedge clk);
        rst[k] = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rst_in_ready", 32'(in_ready_v[k]), 32'd1);
        chk("rst_done",     32'(done_v[k]),     32'd0);
        chk("rst_err",      32'(err_v[k]),      32'd0);
        chk("rst_wb_dr",    32'(wb_dr_v[k]),    32'd0);
        chk("rst_wb_data",  32'(wb_data_v[k]),  32'd0);
        chk("rst_nzp",      32'(nzp_v[k]),      32'b010);
        chk("rst_alu_a",    32'(alu_a_v[k]),    32'd0);
        chk("rst_alu_b",    32'(alu_b_v[k]),    32'd0);
        chk("rst_alu_op",   32'(alu_op_v[k]),   32'd0);
    endtask

    // Issue one instruction at a negedge and check its retirement.
    task automatic issue(input int k, input vec_t e);
        int n;
        int c;
        n = 0;
        while (!in_ready_v[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(in_ready_v[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_instr[k] = e.instr;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_instr[k] = 16'($urandom());
        c = 1;
        while (!done_v[k] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("latency", 32'(c), e.err ? 32'd1 : 32'(k + 2));
        chk("err",     32'(err_v[k]),     32'(e.err));
        chk("wb_dr",   32'(wb_dr_v[k]),   32'(e.dr));
        chk("wb_data", 32'(wb_data_v[k]), 32'(e.data));
        chk("nzp",     32'(nzp_v[k]),     32'(e.nzp));
        chk("alu_op",  32'(alu_op_v[k]),  32'(mop));
        @(negedge clk);
        chk("ready_after", 32'(in_ready_v[k]), 32'd1);
        chk("done_pulse",  32'(done_v[k]),     32'd0);
    endtask

    // in_valid held high with four instructions queued behind each other.
    task automatic back_to_back(input int k);
        logic [15:0] list [4];
        vec_t q [$];
        vec_t e, x;
        int   n, got, last_acc;
        logic acc_prev;
        list[0] = 16'h1265; list[1] = 16'h5464; list[2] = 16'h967F; list[3] = 16'h18C1;
        n = 0; got = 0; last_acc = -1; acc_prev = 1'b0;
        in_valid[k] = 1'b1;
        in_instr[k] = list[0];
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            if (acc_prev) begin
                if (n < 4) in_instr[k] = list[n];
                else       in_valid[k] = 1'b0;
            end
            if (done_v[k]) begin
                if (q.size() > 0) begin
                    x = q.pop_front();
                    chk("b2b_wb_data", 32'(wb_data_v[k]), 32'(x.data));
                    chk("b2b_wb_dr",   32'(wb_dr_v[k]),   32'(x.dr));
                end
                got++;
            end
            acc_prev = in_ready_v[k] && in_valid[k];
            if (acc_prev) begin
                if (last_acc >= 0) chk("b2b_period", 32'(cyc - last_acc), 32'(k + 3));
                last_acc = cyc;
                model(list[n], e);
                q.push_back(e);
                n++;
            end
            @(negedge clk);
        end
        in_valid[k] = 1'b0;
        chk("b2b_retired", 32'(got), 32'd4);
    endtask

    task automatic reset_mid_exec(input int k);
        vec_t e;
        do_reset(k);
        in_valid[k] = 1'b1;
        in_instr[k] = 16'h1265;
        @(negedge clk);
        in_valid[k] = 1'b0;
        rst[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midrst_ready", 32'(in_ready_v[k]), 32'd1);
            chk("midrst_done",  32'(done_v[k]),     32'd0);
            @(negedge clk);
        end
        rst[k] = 1'b0;
        @(negedge clk);
        chk("midrst_nzp",  32'(nzp_v[k]),  32'b010);
        chk("midrst_done2", 32'(done_v[k]), 32'd0);
        model_reset();
        // R1 must still be 0, so this yields 5 again rather than 10.
        model(16'h1265, e);
        issue(k, e);
    endtask

    vec_t tbl [7];

    initial begin
        vec_t e;
        logic [15:0] ri;
        int unsigned pick;

        tbl[0] = '{instr: 16'h1265, dr: 3'd1, data: 16'h0005, nzp: 3'b001, err: 1'b0};
        tbl[1] = '{instr: 16'h5464, dr: 3'd2, data: 16'h0004, nzp: 3'b001, err: 1'b0};
        tbl[2] = '{instr: 16'h967F, dr: 3'd3, data: 16'hFFFA, nzp: 3'b100, err: 1'b0};
        tbl[3] = '{instr: 16'h18C1, dr: 3'd4, data: 16'hFFFF, nzp: 3'b100, err: 1'b0};
        tbl[4] = '{instr: 16'h1A7B, dr: 3'd5, data: 16'h0000, nzp: 3'b010, err: 1'b0};
        tbl[5] = '{instr: 16'h1C30, dr: 3'd6, data: 16'hFFF0, nzp: 3'b100, err: 1'b0};
        tbl[6] = '{instr: 16'h0000, dr: 3'd0, data: 16'h0000, nzp: 3'b100, err: 1'b1};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; in_instr[k] = 16'h0000;
        end

        for (int k = 0; k < 2; k++) begin
            cur_k = k;
            do_reset(k);
            for (int i = 0; i < 7; i++) begin
                model(tbl[i].instr, e);  // keeps the model in step; table holds expectations
                issue(k, tbl[i]);
            end
            for (int i = 0; i < 24; i++) begin
                ri = 16'($urandom());
                pick = $urandom_range(0, 9);
                if (pick < 3)      ri[15:12] = 4'b0001;
                else if (pick < 6) ri[15:12] = 4'b0101;
                else if (pick < 9) ri[15:12] = 4'b1001;
                model(ri, e);
                issue(k, e);
            end
            do_reset(k);
            back_to_back(k);
            reset_mid_exec(k);
            rst[k] = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
